edge_overlay: RTL
=================

// Module: edge_overlay
// PURPOSE
//  Downstream consumer of the sobel edge stage. Re-aligns the original 24-bit RGB stream
//  with the delayed edge stream through a pixel FIFO (push on input de, pop on edge de).
//  Composites the two per a runtime mode and emits one aligned video stream for display.
//  Latency-agnostic: any sobel latency up to DEPTH pixels is absorbed without retuning.
// PARAMETERS
//  DEPTH      4096  FIFO depth in pixels, power of 2, >= max edge-stage latency in pixels
//  ADDR_W     12    log2(DEPTH)
// PORTS
//  clk            in   1   pixel clock
//  rst            in   1   asynchronous, active-high reset
//  rgb_in         in   24  original pixel, same stream fed to the edge stage
//  vsync_in       in   1   original vsync
//  de_in          in   1   original data enable; pushes rgb_in into FIFO
//  edge_in        in   24  edge pixel, all-ones = edge, zero = no edge
//  edge_hsync     in   1   edge-stream hsync
//  edge_vsync     in   1   edge-stream vsync
//  edge_de        in   1   edge-stream data enable; pops one FIFO pixel
//  mode           in   2   0 original, 1 edge only, 2 overlay, 3 dimmed overlay
//  overlay_color  in   24  colour drawn on edge pixels in modes 2/3
//  rgb_out        out  24  composited pixel
//  hsync_out      out  1   edge_hsync delayed 2 cycles
//  vsync_out      out  1   edge_vsync delayed 2 cycles
//  de_out         out  1   edge_de delayed 2 cycles
//  ovf            out  1   sticky: push while full
//  unf            out  1   sticky: pop while empty
//  edge_count     out  22  edge pixels in last completed frame (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO pointers/count 0, sticky flags 0, delay pipes 0.
//  Latency: edge_* sampled at cycle N -> *_out and rgb_out valid at N+2 (registered RAM read
//   at N+1, registered composite at N+2). Sync/de pipe is 2 flops, no other delay.
//  FIFO: no read-through; push and pop same cycle allowed at any count except empty
//   (empty+pop = underflow even if push same cycle). Full+push+pop: push accepted.
//  Overflow: push while full (and no pop) dropped, ovf<=1. Underflow: pop while empty ->
//   composite uses original pixel 24'h0, unf<=1. Pointers wrap mod DEPTH.
//  Resync: on rising edge of vsync_in, if ovf|unf set: FIFO pointers/count cleared, ovf/unf
//   cleared same cycle; a push in that cycle is kept as first entry. Otherwise no action.
//  Composite (edge = |edge_in delayed 1): mode 0 orig; 1 edge_in; 2 edge?overlay_color:orig;
//   3 edge?overlay_color:{orig[23:17]>>0..} i.e. each 8-bit channel shifted right by 1.
//  mode sampled with edge_de at cycle N; mid-frame mode change applies per pixel.
//  When delayed de = 0, rgb_out = 24'h0.
//  rst mid-frame: immediate clear; output stream resumes aligned after next vsync_in only
//   if edge stage also reset; otherwise unf/ovf flags the misalignment and resync repairs it.
// CONFIGURATION
//  EDGE_OVERLAY_STATS_EN defined: 22-bit counter increments per output pixel with de and
//   edge; on rising edge of vsync_out, edge_count <= counter, counter <= 0 (saturates 2^22-1).
//  Not defined: no counter logic; edge_count tied to 22'h0.
// STRUCTURE
//  sobel_pkg (shared): MODE_ORIG=0, MODE_EDGE=1, MODE_OVERLAY=2, MODE_DIM=3; PIX_W=24.
//  Sub-module pixel_fifo: single-clock FIFO, registered read, full/empty/count, DEPTH param;
//   inferred dual-port RAM. Compositor, sync pipe, flags, stats stay in edge_overlay.
// TESTING
//  1 Edge stream = input delayed 1030 px, 64x8 frame, mode 2, colour 24'hFF0000: edge px ->
//    FF0000, others == original pixel at same coordinate; de_out = edge_de delayed 2.
//  2 mode 3, orig 24'h80_40_FE non-edge -> 24'h40_20_7F; edge px -> overlay_color.
//  3 DEPTH=16, delay 20 px: ovf=1 on 17th push; next vsync_in rise clears ovf and FIFO.
//  4 edge_de pulse before any de_in: unf=1, rgb_out mode 0 = 24'h000000.
//  5 Full FIFO, push+pop same cycle: count stays DEPTH, ovf stays 0.
//  6 STATS_EN, frame with 37 edge px: edge_count=37 after vsync_out rise; without macro = 0.
//  7 rst asserted mid-line: all outputs 0 asynchronously, count 0, flags 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared pixel width, compositing modes and dimming helper
package sobel_pkg;
  localparam int PIX_W = 24;
  typedef enum logic [1:0] {
    MODE_ORIG    = 2'd0,
    MODE_EDGE    = 2'd1,
    MODE_OVERLAY = 2'd2,
    MODE_DIM     = 2'd3
  } mode_t;
  function automatic logic [PIX_W-1:0] dim(input logic [PIX_W-1:0] p);
    return (p >> 1) & 24'h7f7f7f;
  endfunction
endpackage

// File: rtl/edge_overlay_pixel_fifo.sv
// pixel_fifo: single-clock FIFO with registered read and synchronous clear
module pixel_fifo
  import sobel_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  logic [PIX_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0] count;
  logic wr_en, rd_en;
  assign full  = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  // a pop frees the slot, so full+push+pop still accepts the push
  assign wr_en = push && (clr || !full || pop);
  assign rd_en = pop && !empty && !clr;
  always_ff @(posedge clk) begin
    if (wr_en) mem[clr ? '0 : wptr] <= wr_data;
    if (pop) rd_data <= mem[rptr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= ADDR_W'(push);
      rptr  <= '0;
      count <= (ADDR_W+1)'(push);
    end else begin
      wptr  <= wptr + ADDR_W'(wr_en);
      rptr  <= rptr + ADDR_W'(rd_en);
      count <= count + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(rd_en);
    end
  end
endmodule

// File: rtl/edge_overlay.sv
// edge_overlay: realigns original video with the edge stream and composites them.
// Optional EDGE_OVERLAY_STATS_EN adds a per-frame edge pixel counter.
module edge_overlay
  import sobel_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] rgb_in,
  input  logic             vsync_in,
  input  logic             de_in,
  input  logic [PIX_W-1:0] edge_in,
  input  logic             edge_hsync,
  input  logic             edge_vsync,
  input  logic             edge_de,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] overlay_color,
  output logic [PIX_W-1:0] rgb_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de_out,
  output logic             ovf,
  output logic             unf,
  output logic [21:0]      edge_count
);
  logic [PIX_W-1:0] fifo_q, epix1, orig, comp;
  logic full, empty, clr, vs_q, de1, hs1, vs1, edge1, und1;
  mode_t mode1;
  assign clr = vsync_in && !vs_q && (ovf || unf);
  pixel_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk(clk), .rst(rst), .clr(clr), .push(de_in), .pop(edge_de),
    .wr_data(rgb_in), .rd_data(fifo_q), .full(full), .empty(empty)
  );
  always_comb begin
    orig = und1 ? '0 : fifo_q;
    comp = mode1 == MODE_ORIG ? orig :
           mode1 == MODE_EDGE ? epix1 :
           edge1 ? overlay_color :
           mode1 == MODE_OVERLAY ? orig : dim(orig);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      de1       <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      edge1     <= 1'b0;
      und1      <= 1'b0;
      epix1     <= '0;
      mode1     <= MODE_ORIG;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      rgb_out   <= '0;
    end else begin
      vs_q      <= vsync_in;
      ovf       <= !clr && (ovf || (de_in && full && !edge_de));
      unf       <= !clr && (unf || (edge_de && empty));
      de1       <= edge_de;
      hs1       <= edge_hsync;
      vs1       <= edge_vsync;
      edge1     <= |edge_in;
      epix1     <= edge_in;
      mode1     <= mode_t'(mode);
      und1      <= edge_de && (empty || clr);
      de_out    <= de1;
      hsync_out <= hs1;
      vsync_out <= vs1;
      rgb_out   <= de1 ? comp : '0;
    end
  end
`ifdef EDGE_OVERLAY_STATS_EN
  logic [21:0] cnt;
  logic e2, vs2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      e2         <= 1'b0;
      vs2        <= 1'b0;
      edge_count <= '0;
    end else begin
      e2  <= de1 && edge1;
      vs2 <= vsync_out;
      if (vsync_out && !vs2) begin
        edge_count <= cnt;
        cnt        <= '0;
      end else if (de_out && e2 && cnt != '1) begin
        cnt <= cnt + 22'd1;
      end
    end
  end
`else
  assign edge_count = '0;
`endif
endmodule
